// File: rtl/cfg_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : cfg_chain_loader
// Purpose  : Streams host words into NUM_CHAINS serial config chains and, in
//            verify mode, counts bits returned on config_out that differ.
// Revision : 1.0  initial release
// ============================================================================
module cfg_chain_loader #(
    parameter int NUM_CHAINS   = 4,
    parameter int WORD_WIDTH   = 32,
    parameter int CONFIG_WIDTH = 2048,
    parameter int CLK_DIV      = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  sys_reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  abort,
    input  logic                  wr_valid,
    input  logic [WORD_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic [NUM_CHAINS-1:0] config_in,
    output logic                  config_clk,
    output logic                  config_en,
    input  logic [NUM_CHAINS-1:0] config_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CNT_WIDTH-1:0]  mismatch_count
);

    localparam int c_lane   = WORD_WIDTH / NUM_CHAINS;
    localparam int c_lane_w = (c_lane > 1) ? $clog2(c_lane) : 1;
    localparam int c_bit_w  = $clog2(CONFIG_WIDTH + 1);
    localparam int c_div_w  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_pop_w  = $clog2(NUM_CHAINS + 1);
    localparam int c_sum_w  = CNT_WIDTH + 1;

    localparam logic [c_lane_w-1:0] c_lane_last = c_lane_w'(c_lane - 1);
    localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(CLK_DIV - 1);
    localparam logic [c_bit_w-1:0]  c_bit_end   = c_bit_w'(CONFIG_WIDTH);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_load     = 3'd1;
    localparam logic [2:0] c_st_shift_lo = 3'd2;
    localparam logic [2:0] c_st_shift_hi = 3'd3;
    localparam logic [2:0] c_st_done     = 3'd4;

    logic [2:0]            r_state;
    logic                  r_mode;
    logic [WORD_WIDTH-1:0] r_word;
    logic [c_lane_w-1:0]   r_lane_idx;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic [c_div_w-1:0]    r_div_cnt;
    logic                  r_wr_ready;
    logic [NUM_CHAINS-1:0] r_config_in;
    logic                  r_config_clk;
    logic                  r_config_en;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic [CNT_WIDTH-1:0]  r_mismatch;

    logic [NUM_CHAINS-1:0] w_first_bits;
    logic [NUM_CHAINS-1:0] w_next_bits;
    logic [c_lane_w-1:0]   w_lane_dec;
    logic [NUM_CHAINS-1:0] w_diff;
    logic [c_pop_w-1:0]    w_pop;
    logic [c_sum_w-1:0]    w_sum;
    logic [CNT_WIDTH-1:0]  w_mm_next;

    assign w_lane_dec = r_lane_idx - c_lane_w'(1);

    // Bits are sent MSB first within each chain's lane of the word.
    for (genvar g = 0; g < NUM_CHAINS; g++) begin : g_lane
        logic [c_lane-1:0] w_new_lane;
        logic [c_lane-1:0] w_cur_lane;
        assign w_new_lane      = wr_data[g*c_lane +: c_lane];
        assign w_cur_lane      = r_word[g*c_lane +: c_lane];
        assign w_first_bits[g] = w_new_lane[c_lane-1];
        assign w_next_bits[g]  = w_cur_lane[w_lane_dec];
    end

    assign w_diff = config_out ^ r_config_in;

    always_comb begin
        w_pop = '0;
        for (int c = 0; c < NUM_CHAINS; c++) begin
            w_pop = w_pop + c_pop_w'(w_diff[c]);
        end
    end

    assign w_sum     = {1'b0, r_mismatch} + c_sum_w'(w_pop);
    assign w_mm_next = w_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_sum[CNT_WIDTH-1:0];

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            r_state      <= c_st_idle;
            r_mode       <= 1'b0;
            r_word       <= '0;
            r_lane_idx   <= '0;
            r_bit_cnt    <= '0;
            r_div_cnt    <= '0;
            r_wr_ready   <= 1'b0;
            r_config_in  <= '0;
            r_config_clk <= 1'b0;
            r_config_en  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_mismatch   <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort && r_busy) begin
                r_state      <= c_st_idle;
                r_wr_ready   <= 1'b0;
                r_config_clk <= 1'b0;
                r_config_en  <= 1'b0;
                r_config_in  <= '0;
                r_busy       <= 1'b0;
                r_error      <= 1'b1;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (start && !abort) begin
                            r_state     <= c_st_load;
                            r_mode      <= mode;
                            r_mismatch  <= '0;
                            r_error     <= 1'b0;
                            r_busy      <= 1'b1;
                            r_config_en <= 1'b1;
                            r_wr_ready  <= 1'b1;
                            r_bit_cnt   <= '0;
                        end
                    end
                    c_st_load: begin
                        if (wr_valid && r_wr_ready) begin
                            r_word      <= wr_data;
                            r_lane_idx  <= c_lane_last;
                            r_config_in <= w_first_bits;
                            r_wr_ready  <= 1'b0;
                            r_div_cnt   <= '0;
                            r_state     <= c_st_shift_lo;
                        end
                    end
                    c_st_shift_lo: begin
                        if (r_div_cnt == c_div_last) begin
                            r_div_cnt    <= '0;
                            r_config_clk <= 1'b1;
                            r_bit_cnt    <= r_bit_cnt + c_bit_w'(1);
                            r_state      <= c_st_shift_hi;
                            // The chain tail is compared against the bit being shifted in now.
                            if (r_mode) begin
                                r_mismatch <= w_mm_next;
                            end
                        end else begin
                            r_div_cnt <= r_div_cnt + c_div_w'(1);
                        end
                    end
                    c_st_shift_hi: begin
                        if (r_div_cnt == c_div_last) begin
                            r_div_cnt    <= '0;
                            r_config_clk <= 1'b0;
                            if (r_bit_cnt == c_bit_end) begin
                                r_state     <= c_st_done;
                                r_done      <= 1'b1;
                                r_busy      <= 1'b0;
                                r_config_en <= 1'b0;
                                r_error     <= r_mode && (r_mismatch != '0);
                            end else if (r_lane_idx == '0) begin
                                r_state    <= c_st_load;
                                r_wr_ready <= 1'b1;
                            end else begin
                                r_lane_idx  <= w_lane_dec;
                                r_config_in <= w_next_bits;
                                r_state     <= c_st_shift_lo;
                            end
                        end else begin
                            r_div_cnt <= r_div_cnt + c_div_w'(1);
                        end
                    end
                    c_st_done: begin
                        r_state <= c_st_idle;
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

    assign wr_ready       = r_wr_ready;
    assign config_in      = r_config_in;
    assign config_clk     = r_config_clk;
    assign config_en      = r_config_en;
    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign mismatch_count = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_cfg_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_chain_loader
// Purpose  : Self-checking bench: shift-register chain model plus a reference
//            model of expected chain contents, mismatch counts and latency.
// Revision : 1.0  initial release
// ============================================================================
module tb_cfg_chain_loader;

    localparam int NC     = 2;
    localparam int WW     = 8;
    localparam int CW     = 16;
    localparam int CD     = 2;
    localparam int CNTW   = 8;
    localparam int LANE   = WW / NC;
    localparam int NWORDS = CW * NC / WW;

    logic            clk = 1'b0;
    logic            sys_reset;
    logic            start;
    logic            mode;
    logic            abort;
    logic            wr_valid;
    logic [WW-1:0]   wr_data;
    logic            wr_ready;
    logic [NC-1:0]   config_in;
    logic            config_clk;
    logic            config_en;
    logic [NC-1:0]   config_out;
    logic            busy;
    logic            done;
    logic            error;
    logic [CNTW-1:0] mismatch_count;

    int n_tests;
    int n_fail;
    int rises;
    logic [CW-1:0] chain [NC];
    logic [WW-1:0] wq [NWORDS];

    cfg_chain_loader #(
        .NUM_CHAINS  (NC),
        .WORD_WIDTH  (WW),
        .CONFIG_WIDTH(CW),
        .CLK_DIV     (CD),
        .CNT_WIDTH   (CNTW)
    ) u_dut (
        .clk           (clk),
        .sys_reset     (sys_reset),
        .start         (start),
        .mode          (mode),
        .abort         (abort),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .config_in     (config_in),
        .config_clk    (config_clk),
        .config_en     (config_en),
        .config_out    (config_out),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .mismatch_count(mismatch_count)
    );

    always #5 clk = ~clk;

    // Fabric model: one CW-bit shift register per chain, tail bit on config_out.
    always @(posedge config_clk) begin
        rises = rises + 1;
        for (int c = 0; c < NC; c++) begin
            chain[c] = {chain[c][CW-2:0], config_in[c]};
        end
    end

    always_comb begin
        config_out = '0;
        for (int c = 0; c < NC; c++) begin
            config_out[c] = chain[c][CW-1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Chain c after a full pass holds lane c of every word, first word in the MSBs.
    function automatic logic [CW-1:0] exp_chain(input int c);
        logic [CW-1:0] v;
        v = '0;
        for (int w = 0; w < NWORDS; w++) begin
            v = (v << LANE) | CW'((wq[w] >> (c * LANE)) & ((1 << LANE) - 1));
        end
        return v;
    endfunction

    // kill: 0 none, 1 abort, 2 reset; applied right after the 7th shift-clock rise.
    task automatic run_pass(input bit vmode, input int stall_idx, input int stall_len,
                            input int kill, output int lat);
        int widx;
        int scnt;
        int n;
        int dcount;
        bit hs;
        widx = 0;
        scnt = 0;
        lat  = -1;
        rises = 0;
        @(negedge clk);
        start = 1'b1;
        mode  = vmode;
        wr_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 400) begin
            if (done) begin
                lat = n + 1;
                break;
            end
            if (kill != 0 && rises == 7 && config_clk) begin
                wr_valid = 1'b0;
                if (kill == 1) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    chk("abort_busy", busy, 0);
                    chk("abort_en", config_en, 0);
                    chk("abort_cclk", config_clk, 0);
                    chk("abort_error", error, 1);
                    dcount = 0;
                    for (int i = 0; i < 12; i++) begin
                        if (done) dcount++;
                        @(negedge clk);
                    end
                    chk("abort_no_done", dcount, 0);
                end else begin
                    sys_reset = 1'b0;
                    #1;
                    chk("async_reset_outs",
                        {wr_ready, config_in, config_clk, config_en, busy, done, error, mismatch_count}, 0);
                    @(negedge clk);
                    @(negedge clk);
                    sys_reset = 1'b1;
                    @(negedge clk);
                end
                return;
            end
            if (wr_ready && widx == stall_idx && scnt < stall_len) begin
                wr_valid = 1'b0;
                scnt++;
                chk("stall_cclk_low", config_clk, 0);
            end else if (wr_ready && widx < NWORDS) begin
                wr_valid = 1'b1;
                wr_data  = wq[widx];
            end else begin
                wr_valid = 1'b0;
            end
            hs = wr_valid && wr_ready;
            @(negedge clk);
            n++;
            if (hs) widx++;
        end
        wr_valid = 1'b0;
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic do_pass(input bit vmode, input int sidx, input int slen, input string tag);
        logic [CW-1:0] snap [NC];
        int exp_mm;
        int lat;
        exp_mm = 0;
        for (int c = 0; c < NC; c++) begin
            snap[c] = chain[c];
            if (vmode) exp_mm += $countones(exp_chain(c) ^ snap[c]);
        end
        if (exp_mm > (1 << CNTW) - 1) exp_mm = (1 << CNTW) - 1;
        run_pass(vmode, sidx, slen, 0, lat);
        chk({tag, "_latency"}, lat, 2 + NWORDS + CW * 2 * CD + slen);
        chk({tag, "_mismatch"}, mismatch_count, exp_mm);
        chk({tag, "_error"}, error, (vmode && exp_mm != 0) ? 1 : 0);
        @(negedge clk);
        chk({tag, "_done_once"}, done, 0);
        chk({tag, "_busy_off"}, busy, 0);
        chk({tag, "_en_off"}, config_en, 0);
        for (int c = 0; c < NC; c++) begin
            chk({tag, "_chain"}, chain[c], exp_chain(c));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int wi;
        int bi;
        n_tests   = 0;
        n_fail    = 0;
        rises     = 0;
        start     = 1'b0;
        mode      = 1'b0;
        abort     = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        sys_reset = 1'b0;
        for (int c = 0; c < NC; c++) chain[c] = '0;
        #1;
        chk("reset_outs",
            {wr_ready, config_in, config_clk, config_en, busy, done, error, mismatch_count}, 0);
        repeat (3) @(negedge clk);
        sys_reset = 1'b1;

        wr_valid = 1'b1;
        wr_data  = 8'h77;
        repeat (2) @(negedge clk);
        chk("idle_not_ready", wr_ready, 0);
        chk("idle_not_busy", busy, 0);
        wr_valid = 1'b0;

        wq = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        do_pass(1'b0, -1, 0, "prog");
        chk("chain0_bits", chain[0], 16'h5CF0);
        chk("chain1_bits", chain[1], 16'hA3F0);

        do_pass(1'b1, -1, 0, "verify_same");
        chk("verify_same_unchanged0", chain[0], 16'h5CF0);

        wq[2] = 8'hFE;
        do_pass(1'b1, -1, 0, "verify_bad");
        chk("verify_bad_count", mismatch_count, 1);

        wq = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        do_pass(1'b0, 3, 10, "stall");

        run_pass(1'b0, -1, 0, 1, lat);
        do_pass(1'b0, -1, 0, "after_abort");

        run_pass(1'b0, -1, 0, 2, lat);
        do_pass(1'b0, -1, 0, "after_reset");

        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < NWORDS; w++) wq[w] = WW'($urandom);
            do_pass(1'b0, $urandom_range(0, NWORDS - 1), $urandom_range(0, 5), "rand_prog");
            if ($urandom_range(0, 2) != 0) begin
                wi = $urandom_range(0, NWORDS - 1);
                bi = $urandom_range(0, WW - 1);
                wq[wi][bi] = ~wq[wi][bi];
            end
            do_pass(1'b1, -1, 0, "rand_verify");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
